// File: rtl/ex_mul_div_unit.sv
// rtl/ex_mul_div_unit.sv - RV32M multi-cycle multiply/divide unit for the EX stage
package ex_mul_div_pkg;
  typedef enum logic [2:0] {
    MULf    = 3'd0,
    MULHf   = 3'd1,
    MULHSUf = 3'd2,
    MULHUf  = 3'd3,
    DIVf    = 3'd4,
    DIVUf   = 3'd5,
    REMf    = 3'd6,
    REMUf   = 3'd7
  } MUL_DIV_t;
endpackage

module ex_mul_div_unit
  import ex_mul_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  MUL_DIV_t    func_i,
  input  logic [31:0] src0_i,
  input  logic [31:0] src1_i,
  input  logic        kill_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state_q, state_d;
  MUL_DIV_t    func_q, func_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [31:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sign0_q, sign0_d;
  logic        sign1_q, sign1_d;
  logic [31:0] result_q, result_d;

  logic        in_is_div, in_signed_div, in_div0, in_ovf;
  logic [31:0] in_special;

  assign in_is_div     = func_i inside {DIVf, DIVUf, REMf, REMUf};
  assign in_signed_div = func_i inside {DIVf, REMf};
  assign in_div0       = (src1_i == 32'd0);
  assign in_ovf        = in_signed_div && (src0_i == 32'h8000_0000) && (src1_i == 32'hFFFF_FFFF);
  assign in_special    = in_div0 ? ((func_i inside {REMf, REMUf}) ? src0_i : 32'hFFFF_FFFF)
                                 : ((func_i == REMf) ? 32'd0 : 32'h8000_0000);

  // Low 64 bits of the product of 64-bit extended operands are correct for every signedness mix.
  logic        a_ext, b_ext;
  logic [63:0] mul_a, mul_b, prod;

  assign a_ext = (func_q != MULHUf) & op_a_q[31];
  assign b_ext = (func_q inside {MULf, MULHf}) & op_b_q[31];
  assign mul_a = {{32{a_ext}}, op_a_q};
  assign mul_b = {{32{b_ext}}, op_b_q};
  assign prod  = mul_a * mul_b;

  // op_a_q doubles as the dividend/quotient shift register while dividing.
  logic [32:0] shifted, diff;
  logic [31:0] quo_next, rem_next, quo_fix, rem_fix;
  logic        div_signed;

  assign shifted    = {rem_q, op_a_q[31]};
  assign diff       = shifted - {1'b0, op_b_q};
  assign quo_next   = {op_a_q[30:0], ~diff[32]};
  assign rem_next   = diff[32] ? shifted[31:0] : diff[31:0];
  assign div_signed = func_q inside {DIVf, REMf};
  assign quo_fix    = (div_signed && (sign0_q ^ sign1_q)) ? (32'd0 - quo_next) : quo_next;
  assign rem_fix    = (div_signed && sign0_q) ? (32'd0 - rem_next) : rem_next;

  always_comb begin
    state_d  = state_q;
    func_d   = func_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    sign0_d  = sign0_q;
    sign1_d  = sign1_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          func_d  = func_i;
          sign0_d = src0_i[31];
          sign1_d = src1_i[31];
          cnt_d   = 5'd0;
          rem_d   = 32'd0;
          if (!in_is_div) begin
            op_a_d  = src0_i;
            op_b_d  = src1_i;
            state_d = MUL;
          end else if (in_div0 || in_ovf) begin
            result_d = in_special;
            state_d  = DONE;
          end else begin
            op_a_d  = (in_signed_div && src0_i[31]) ? (32'd0 - src0_i) : src0_i;
            op_b_d  = (in_signed_div && src1_i[31]) ? (32'd0 - src1_i) : src1_i;
            state_d = DIV;
          end
        end
      end
      MUL: begin
        result_d = (func_q == MULf) ? prod[31:0] : prod[63:32];
        state_d  = DONE;
      end
      DIV: begin
        op_a_d = quo_next;
        rem_d  = rem_next;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          result_d = (func_q inside {DIVf, DIVUf}) ? quo_fix : rem_fix;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A flush wins over everything, including a same-cycle request.
    if (kill_i) begin
      state_d  = IDLE;
      cnt_d    = 5'd0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      func_q   <= MULf;
      op_a_q   <= 32'd0;
      op_b_q   <= 32'd0;
      rem_q    <= 32'd0;
      cnt_q    <= 5'd0;
      sign0_q  <= 1'b0;
      sign1_q  <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      func_q   <= func_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      sign0_q  <= sign0_d;
      sign1_q  <= sign1_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign stall_o  = ((state_q == IDLE) && start_i && !kill_i) || (state_q == MUL) || (state_q == DIV);
  assign done_o   = (state_q == DONE) && !kill_i;
  assign result_o = result_q;

endmodule

// File: tb/tb_ex_mul_div_unit.sv
// tb/tb_ex_mul_div_unit.sv - randomized self-checking bench for ex_mul_div_unit
module tb_ex_mul_div_unit;
  import ex_mul_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  MUL_DIV_t    func_i;
  logic [31:0] src0_i;
  logic [31:0] src1_i;
  logic        kill_i;
  logic        busy_o;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] last_res = 32'd0;

  ex_mul_div_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .func_i   (func_i),
    .src0_i   (src0_i),
    .src1_i   (src1_i),
    .kill_i   (kill_i),
    .busy_o   (busy_o),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_model(input MUL_DIV_t f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = 64'd0;
    case (f)
      MULf:    begin p = sa * sb; return p[31:0];  end
      MULHf:   begin p = sa * sb; return p[63:32]; end
      MULHSUf: begin p = sa * ub; return p[63:32]; end
      MULHUf:  begin p = ua * ub; return p[63:32]; end
      DIVf: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      DIVUf: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      REMf: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      REMUf: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input MUL_DIV_t f, input logic [31:0] a, input logic [31:0] b);
    if (f inside {MULf, MULHf, MULHSUf, MULHUf}) return 2;
    if (b == 32'd0) return 1;
    if ((f inside {DIVf, REMf}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic scramble_inputs();
    logic [2:0] r;
    r      = 3'($urandom_range(0, 7));
    func_i = MUL_DIV_t'(r);
    src0_i = $urandom;
    src1_i = $urandom;
  endtask

  task automatic run_op(input MUL_DIV_t f, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp_res;
    int          exp_lat, stalls, done_at;
    exp_res = ref_model(f, a, b);
    exp_lat = ref_latency(f, a, b);
    @(negedge clk);
    start_i = 1'b1; kill_i = 1'b0; func_i = f; src0_i = a; src1_i = b;
    #1;
    stalls  = stall_o ? 1 : 0;
    done_at = -1;
    for (int c = 1; c <= 40 && done_at < 0; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      scramble_inputs();
      #1;
      if (stall_o) stalls++;
      if (done_o) done_at = c;
    end
    check({tag, " latency"}, 32'(done_at), 32'(exp_lat));
    check({tag, " stall"}, 32'(stalls), 32'(exp_lat));
    check({tag, " result"}, result_o, exp_res);
    if (done_at >= 0) last_res = exp_res;
    @(negedge clk);
    #1;
    check({tag, " post done/busy"}, {30'd0, done_o, busy_o}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; kill_i = 1'b0;
    func_i = MULf; src0_i = 32'd0; src1_i = 32'd0;
    #1;
    check("reset outputs", {29'd0, busy_o, stall_o, done_o}, 32'd0);
    check("reset result", result_o, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(MULf,    32'h0000_0007, 32'hFFFF_FFFD, "mul 7x-3");
    run_op(MULHf,   32'h8000_0000, 32'h8000_0000, "mulh min");
    run_op(MULHUf,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu max");
    run_op(MULHSUf, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    run_op(DIVf,    32'hFFFF_FFF9, 32'd2,         "div -7/2");
    run_op(REMf,    32'hFFFF_FFF9, 32'd2,         "rem -7/2");
    run_op(DIVUf,   32'd100,       32'd7,         "divu 100/7");
    run_op(REMUf,   32'd100,       32'd7,         "remu 100/7");
    run_op(DIVUf,   32'd5,         32'd0,         "divu by0");
    run_op(REMf,    32'd5,         32'd0,         "rem by0");
    run_op(DIVf,    32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
    run_op(REMf,    32'h8000_0000, 32'hFFFF_FFFF, "rem ovf");

    // Flush at cycle 10 of a divide.
    begin
      int saw_done;
      saw_done = 0;
      @(negedge clk);
      start_i = 1'b1; func_i = DIVf; src0_i = 32'd1000; src1_i = 32'd3;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        start_i = 1'b0;
        #1;
        if (done_o) saw_done = 1;
      end
      kill_i = 1'b1;
      @(negedge clk);
      kill_i = 1'b0;
      #1;
      check("kill busy", {31'd0, busy_o}, 32'd0);
      check("kill done", 32'(saw_done) | {31'd0, done_o}, 32'd0);
      check("kill result held", result_o, last_res);
    end
    run_op(MULf, 32'd6, 32'd7, "mul after kill");

    // Request together with a flush is not taken.
    @(negedge clk);
    start_i = 1'b1; kill_i = 1'b1; func_i = DIVUf; src0_i = 32'd9; src1_i = 32'd3;
    #1;
    check("kill+start stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    start_i = 1'b0; kill_i = 1'b0;
    #1;
    check("kill+start busy", {31'd0, busy_o}, 32'd0);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    start_i = 1'b1; func_i = REMUf; src0_i = 32'd12345; src1_i = 32'd17;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("mid reset outputs", {29'd0, busy_o, stall_o, done_o}, 32'd0);
    check("mid reset result", result_o, 32'd0);
    last_res = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(MULf, 32'd3, 32'd4, "mul 3x4");

    for (int i = 0; i < 48; i++) begin
      logic [2:0] r;
      r = 3'($urandom_range(0, 7));
      run_op(MUL_DIV_t'(r), pick_operand(), pick_operand(), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ex_mul_div_unit.md
# ex_mul_div_unit

Multi-cycle multiply/divide engine in the EX stage, directly downstream of the ID/EX pipeline register. Consumes the registered `mul_div`, `alu_func2` (MUL_DIV_t), `src0` and `src1` fields and produces the RV32M result. While an operation is in flight it holds the front of the pipeline via `stall_o`, then presents a registered result for EX/MEM to capture. Operands are latched at acceptance, so ID/EX contents may change while the unit is busy.

## Interface
- No parameters; datapath width fixed at 32 bits.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start_i`  in  1  `mul_div_o` from ID/EX: request a new operation.
- `func_i`  in  MUL_DIV_t  operation select: MULf, MULHf, MULHSUf, MULHUf, DIVf, DIVUf, REMf, REMUf.
- `src0_i`  in  32  rs1 operand (dividend / multiplicand).
- `src1_i`  in  32  rs2 operand (divisor / multiplier).
- `kill_i`  in  1  flush (branch/jump redirect): abort the in-flight op.
- `busy_o`  out  1  unit not in IDLE.
- `stall_o`  out  1  combinational; freezes PC, IF/ID and ID/EX.
- `done_o`  out  1  one-cycle pulse; `result_o` valid.
- `result_o`  out  32  registered result; held until the next `done_o`.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE → MUL on `start_i` with a MUL* function; IDLE → DIV on `start_i` with a DIV*/REM* function and no special case; IDLE → DONE on `start_i` with a divide special case.
- At acceptance, latch `func_i`, `src0_i`, `src1_i` and the operand signs.
- MUL: form the 64-bit product of the sign/zero-extended operands in one cycle into a product register, then → DONE.
  - Signedness: MUL and MULH are signed × signed; MULHSU is signed × unsigned; MULHU is unsigned × unsigned.
  - MUL returns bits [31:0]; all other MUL* functions return bits [63:32].
- DIV: radix-2 restoring divider on operand magnitudes. DIV/REM take absolute values; DIVU/REMU use operands as-is.
  - 5-bit iteration counter counts 0..31, one quotient bit per cycle.
  - On count 31 → DONE.
  - Sign fix on exit: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
- Special cases, detected at acceptance and bypassing DIV:
  - Divisor = 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: DIV returns 0x80000000; REM returns 0.
- DONE: `result_o` loaded on entry; `done_o` = 1; `busy_o` = 1; then → IDLE unconditionally.
- `stall_o` = (IDLE & `start_i` & !`kill_i`) | MUL | DIV. It is low in DONE so the pipeline advances and EX/MEM captures `result_o`.
- `kill_i` in any state: next state IDLE, no `done_o`, `result_o` unchanged. `kill_i` together with `start_i` in IDLE: the request is not accepted.
- `start_i` is ignored outside IDLE.

## Timing
- Reset (async, any state): state IDLE; counter 0; `result_o` 0x00000000; `done_o` 0; `busy_o` 0. `stall_o` is 0 while `start_i` is low.
- Acceptance cycle is cycle 0.
- MUL*: cycle 1 in MUL, `done_o` in cycle 2. Stall cycles 0–1.
- DIV* normal: cycles 1–32 in DIV, `done_o` in cycle 33. Stall cycles 0–32.
- Special case: `done_o` in cycle 1. Stall cycle 0 only.
- Back-to-back: a new `start_i` is accepted in the cycle after DONE, at the earliest.
- Reset or kill mid-DIV: partial remainder and quotient are discarded; the next op starts clean.

## Test plan
- MUL 0x00000007 × 0xFFFFFFFD → `result_o` 0xFFFFFFEB, `done_o` in cycle 2, `stall_o` high for 2 cycles.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD and REM → 0xFFFFFFFF, `done_o` in cycle 33; DIVU 100 / 7 → 14 and REMU → 2.
- Divide by zero: DIVU 5 / 0 → 0xFFFFFFFF and REM 5 / 0 → 5, each done in cycle 1; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
- `kill_i` at cycle 10 of a DIV → IDLE in cycle 11, no `done_o`, `result_o` keeps its prior value; the next MUL completes correctly.
- `rst_n` low during DIV → all outputs 0 immediately; after release, `start_i` with MUL 3 × 4 → 12.
